// File: rtl/axil_cmd_sequencer.sv
// axil_cmd_sequencer
//   AXI4-Lite master driven by a command stream. It runs one command at a
//   time and returns exactly one response beat per command.
//   Ops: 0=WRITE, 1=READ, 2=POLL (repeat reads until a masked match or the
//   retry limit), 3=reserved (runs as READ).
// Ports
//   clk_i, resetn_i        : clock, synchronous active-low reset
//   cmd_*                  : command stream (valid/ready handshake)
//   rsp_*                  : response beat (valid held until ready)
//   busy_o                 : high from command accept to response handshake
//   m_aw*/m_w*/m_b*        : AXI4-Lite write channels (master side)
//   m_ar*/m_r*             : AXI4-Lite read channels (master side)
module axil_cmd_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int POLL_CNT_W = 16,
  parameter int POLL_GAP   = 16
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [DATA_W-1:0]     cmd_data_i,
  input  logic [DATA_W-1:0]     cmd_mask_i,
  input  logic [POLL_CNT_W-1:0] cmd_limit_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic [1:0]            rsp_status_o,
  output logic [POLL_CNT_W-1:0] rsp_count_o,
  output logic                  busy_o,
  output logic [ADDR_W-1:0]     m_awaddr_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [DATA_W-1:0]     m_wdata_o,
  output logic [DATA_W/8-1:0]   m_wstrb_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  input  logic [1:0]            m_bresp_i,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o,
  output logic [ADDR_W-1:0]     m_araddr_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [DATA_W-1:0]     m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o
);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd2;
  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_ERR   = 2'd1;
  localparam logic [1:0] ST_EXH   = 2'd2;

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WR_B  = 3'd2,
    S_RD_AR = 3'd3,
    S_RD_R  = 3'd4,
    S_GAP   = 3'd5,
    S_RSP   = 3'd6
  } state_e;

  state_e                state_q;
  logic                  cmd_ready_q, busy_q, rsp_valid_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  poll_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q, mask_q, rdata_q;
  logic [POLL_CNT_W-1:0] limit_q, count_q;
  logic [1:0]            status_q;
  logic [GAP_W-1:0]      gap_q;

  logic [POLL_CNT_W-1:0] limit_eff_s, cnt_inc_s;
  logic                  poll_hit_s, aw_done_s, w_done_s;

  // Derived per-cycle terms: effective limit, saturating count, match, write-leg completion.
  always_comb begin
    limit_eff_s = (limit_q == '0) ? POLL_CNT_W'(1) : limit_q;
    cnt_inc_s   = (count_q == '1) ? count_q : count_q + POLL_CNT_W'(1);
    poll_hit_s  = ((m_rdata_i & mask_q) == (data_q & mask_q));
    // A write leg is complete if it already handshook or handshakes this cycle.
    aw_done_s   = !awvalid_q || m_awready_i;
    w_done_s    = !wvalid_q  || m_wready_i;
  end

  // Command FSM; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      poll_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      limit_q     <= '0;
      rdata_q     <= '0;
      count_q     <= '0;
      status_q    <= ST_OK;
      gap_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            addr_q      <= cmd_addr_i;
            data_q      <= cmd_data_i;
            mask_q      <= cmd_mask_i;
            limit_q     <= cmd_limit_i;
            poll_q      <= (cmd_op_i == OP_POLL);
            rdata_q     <= '0;
            count_q     <= '0;
            status_q    <= ST_OK;
            if (cmd_op_i == OP_WRITE) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR;
            end else begin
              // READ, POLL and the reserved op all start with an address read.
              arvalid_q <= 1'b1;
              state_q   <= S_RD_AR;
            end
          end
        end
        S_WR: begin
          if (awvalid_q && m_awready_i) awvalid_q <= 1'b0;
          if (wvalid_q && m_wready_i)   wvalid_q  <= 1'b0;
          if (aw_done_s && w_done_s) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (m_bvalid_i) begin
            bready_q    <= 1'b0;
            status_q    <= (m_bresp_i != 2'd0) ? ST_ERR : ST_OK;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end
        end
        S_RD_AR: begin
          if (m_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (m_rvalid_i) begin
            rready_q <= 1'b0;
            rdata_q  <= m_rdata_i;
            count_q  <= cnt_inc_s;
            if (m_rresp_i != 2'd0) begin
              status_q    <= ST_ERR;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RSP;
            end else if (!poll_q || poll_hit_s) begin
              status_q    <= ST_OK;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RSP;
            end else if (cnt_inc_s >= limit_eff_s) begin
              status_q    <= ST_EXH;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RSP;
            end else if (POLL_GAP == 0) begin
              arvalid_q <= 1'b1;
              state_q   <= S_RD_AR;
            end else begin
              gap_q   <= '0;
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          // Spends exactly POLL_GAP cycles here before the next poll read.
          if (gap_q == GAP_LAST) begin
            arvalid_q <= 1'b1;
            state_q   <= S_RD_AR;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign busy_o       = busy_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rdata_q;
  assign rsp_status_o = status_q;
  assign rsp_count_o  = count_q;
  assign m_awaddr_o   = addr_q;
  assign m_awvalid_o  = awvalid_q;
  assign m_wdata_o    = data_q;
  assign m_wstrb_o    = '1;
  assign m_wvalid_o   = wvalid_q;
  assign m_bready_o   = bready_q;
  assign m_araddr_o   = addr_q;
  assign m_arvalid_o  = arvalid_q;
  assign m_rready_o   = rready_q;

endmodule
